// File: rtl/wb_shared_bus_arbiter_if.sv
// Shared-bus bundle: per-master Wishbone B4 pipelined request/response
// lanes, the single decoder-side bus, and arbiter status.
interface wb_shared_bus_arbiter_if #(
    parameter int NUM_M  = 3,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [NUM_M-1:0]        m_cyc;
    logic [NUM_M-1:0]        m_stb;
    logic [NUM_M-1:0]        m_we;
    logic [NUM_M*ADDR_W-1:0] m_adr;
    logic [NUM_M*DATA_W-1:0] m_dat_w;
    logic [NUM_M*SEL_W-1:0]  m_sel;
    logic [NUM_M-1:0]        m_ack;
    logic [NUM_M-1:0]        m_err;
    logic [NUM_M-1:0]        m_stall;
    logic [DATA_W-1:0]       m_dat_r;

    logic                    s_cyc;
    logic                    s_stb;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_adr;
    logic [DATA_W-1:0]       s_dat_w;
    logic [SEL_W-1:0]        s_sel;
    logic                    s_ack;
    logic                    s_err;
    logic                    s_stall;
    logic [DATA_W-1:0]       s_dat_r;

    logic [NUM_M-1:0]        grant;
    logic                    timeout_evt;

    modport arb (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        output m_ack, m_err, m_stall, m_dat_r,
        output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        input  s_ack, s_err, s_stall, s_dat_r,
        output grant, timeout_evt
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  m_ack, m_err, m_stall, m_dat_r, grant, timeout_evt
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        output s_ack, s_err, s_stall, s_dat_r
    );
endinterface

// File: rtl/wb_shared_bus_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter with per-tenure outstanding
// limit and a bus-timeout watchdog that turns a hung slave into an error.
module wb_shared_bus_arbiter #(
    parameter int NUM_M   = 3,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_shared_bus_arbiter_if.arb bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int OC_W  = $clog2(MAX_OUT + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWNED = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;

    logic [1:0]      state, state_nx;
    logic [IDX_W-1:0] g, g_nx;
    logic [IDX_W-1:0] last, last_nx;
    logic [OC_W-1:0] out_cnt, out_cnt_nx;
    logic [WD_W-1:0] wd_cnt, wd_cnt_nx;
    logic            evt_q, evt_nx;

    logic [IDX_W-1:0] pick;
    logic            pick_vld;
    logic            own_cyc;
    logic            room;
    logic            acc;
    logic            rsp;
    int              gi;

    assign gi      = int'(g);
    assign own_cyc = bus.m_cyc[g];
    assign room    = out_cnt < OC_W'(MAX_OUT);
    assign acc     = bus.s_stb & ~bus.s_stall;
    assign rsp     = bus.s_ack | bus.s_err;

    assign bus.m_dat_r     = bus.s_dat_r;
    assign bus.timeout_evt = evt_q;

    // Scan downward so the nearest requester after 'last' is written last.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = last;
        pick_vld = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_M;
            if (bus.m_cyc[IDX_W'(idx)]) begin
                pick     = IDX_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = '0;
        bus.s_dat_w = '0;
        bus.s_sel   = '0;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        bus.m_stall = '1;
        bus.grant   = '0;
        unique case (1'b1)
            (state == OWNED): begin
                bus.grant[g]   = 1'b1;
                bus.s_cyc      = own_cyc;
                bus.s_stb      = bus.m_stb[g] & room;
                bus.s_we       = bus.m_we[g];
                bus.s_adr      = bus.m_adr[gi*ADDR_W +: ADDR_W];
                bus.s_dat_w    = bus.m_dat_w[gi*DATA_W +: DATA_W];
                bus.s_sel      = bus.m_sel[gi*SEL_W +: SEL_W];
                bus.m_stall[g] = bus.s_stall | ~room;
                bus.m_ack[g]   = bus.s_ack;
                bus.m_err[g]   = bus.s_err;
            end
            (state == ABORT): begin
                bus.grant[g] = 1'b1;
                bus.m_err[g] = evt_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx   = state;
        g_nx       = g;
        last_nx    = last;
        out_cnt_nx = out_cnt;
        wd_cnt_nx  = wd_cnt;
        evt_nx     = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (pick_vld) begin
                    state_nx   = OWNED;
                    g_nx       = pick;
                    last_nx    = pick;
                    out_cnt_nx = '0;
                    wd_cnt_nx  = '0;
                end
            end
            (state == OWNED): begin
                if (!own_cyc) begin
                    state_nx   = IDLE;
                    out_cnt_nx = '0;
                    wd_cnt_nx  = '0;
                end else begin
                    // A response with nothing outstanding is stale; drop it.
                    if (acc && !(rsp && out_cnt != '0))
                        out_cnt_nx = out_cnt + 1'b1;
                    else if (!acc && rsp && out_cnt != '0)
                        out_cnt_nx = out_cnt - 1'b1;

                    if (rsp || out_cnt == '0) begin
                        wd_cnt_nx = '0;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        state_nx  = ABORT;
                        wd_cnt_nx = '0;
                        evt_nx    = 1'b1;
                    end else begin
                        wd_cnt_nx = wd_cnt + 1'b1;
                    end
                end
            end
            (state == ABORT): begin
                if (!own_cyc) begin
                    state_nx   = IDLE;
                    out_cnt_nx = '0;
                    wd_cnt_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            g       <= '0;
            last    <= IDX_W'(NUM_M - 1);
            out_cnt <= '0;
            wd_cnt  <= '0;
            evt_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            g       <= g_nx;
            last    <= last_nx;
            out_cnt <= out_cnt_nx;
            wd_cnt  <= wd_cnt_nx;
            evt_q   <= evt_nx;
        end
    end
endmodule
